// File: rtl/fib_pkg.sv
// ---------------------------------------------------------------------------
// fib_pkg -- definitions shared by the Fibonacci generator and the binary to
// BCD converter that displays its result.
//
//   fib_state_t : IDLE / SHIFT / DONE sequencing states
//   FIB_W       : width of a Fibonacci result in bits
//   FIB_DIGITS  : decimal digits needed to show any FIB_W-bit value
// ---------------------------------------------------------------------------
package fib_pkg;

    localparam int FIB_W      = 32;
    localparam int FIB_DIGITS = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } fib_state_t;

endpackage : fib_pkg

// File: rtl/bcd_add3.sv
// ---------------------------------------------------------------------------
// bcd_add3 -- double-dabble digit correction. A BCD digit of 5 or more would
// become 10 or more after the next left shift, so 3 is added first and the
// carry then lands in the next digit.
//
//   d : BCD digit before correction (0..9)
//   q : corrected digit, ready to be shifted
// ---------------------------------------------------------------------------
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule : bcd_add3

// File: rtl/fib_bcd_conv.sv
// ---------------------------------------------------------------------------
// fib_bcd_conv -- sequential double-dabble converter that turns an unsigned
// binary value into packed BCD, one bit per clock.
//
// Parameters
//   IN_W   : binary input width
//   DIGITS : number of BCD output digits
//
// Ports
//   clk   : clock, all state changes on the rising edge
//   rst   : synchronous active-high reset
//   st    : start request, only looked at while idle
//   bin   : value to convert, captured together with st
//   busy  : high from the edge after capture until DONE is left
//   done  : one-cycle completion strobe, bcd is valid while it is high
//   bcd   : packed BCD result, digit 0 in bits [3:0]; held between results
//   blank : (only with FIB_BCD_BLANK_EN defined) leading-zero blanking mask,
//           bit i set when digit i and every higher digit are zero; bit 0
//           is never set so a zero result still shows one digit
//
// A conversion takes exactly IN_W SHIFT cycles plus one DONE cycle, so done
// rises IN_W edges after the edge that captured st, whatever the value.
// ---------------------------------------------------------------------------
module fib_bcd_conv
    import fib_pkg::*;
#(
    parameter int IN_W   = FIB_W,
    parameter int DIGITS = FIB_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  st,
    input  logic [IN_W-1:0]       bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
`ifdef FIB_BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int CNT_W = $clog2(IN_W + 1);

    fib_state_t          state;
    logic [IN_W-1:0]     bin_sr;    // binary bits still to be consumed, MSB first
    logic [4*DIGITS-1:0] scratch;   // BCD value built so far
    logic [CNT_W-1:0]    cnt;       // shifts remaining in this conversion

    logic [4*DIGITS-1:0] corr;      // scratch after per-digit add-3
    logic [4*DIGITS-1:0] shifted;   // scratch after correction and shift

    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .d (scratch[4*i +: 4]),
            .q (corr[4*i +: 4])
        );
    end

    assign shifted = {corr[4*DIGITS-2:0], bin_sr[IN_W-1]};

`ifdef FIB_BCD_BLANK_EN
    logic [DIGITS-1:0] blank_nxt;
    logic              zero_run;

    // Walk from the most significant digit down; a digit is blank while every
    // digit from the top down to it is zero.
    always_comb begin
        // NOTE: every variable gets a default before any conditional or loop
        // assignment, so no path leaves it unassigned and no latch is inferred.
        blank_nxt = '0;
        zero_run  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run     = zero_run & (shifted[4*i +: 4] == 4'd0);
            blank_nxt[i] = zero_run;
        end
    end
`endif

    // NOTE: all state below is written with non-blocking assignments so every
    // register samples the values from before the edge, whatever the order of
    // statements inside the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
            cnt     <= '0;
            scratch <= '0;
            bin_sr  <= '0;
`ifdef FIB_BCD_BLANK_EN
            blank   <= {{(DIGITS-1){1'b1}}, 1'b0};
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (st) begin
                        bin_sr  <= bin;
                        scratch <= '0;
                        cnt     <= CNT_W'(IN_W);
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end

                SHIFT: begin
                    // {scratch, bin_sr} behaves as one register; the bit that
                    // drops out of the top digit (always zero when DIGITS is
                    // large enough) re-enters at the bottom of bin_sr, where it
                    // can never reach the top again before the conversion ends.
                    scratch <= shifted;
                    bin_sr  <= {bin_sr[IN_W-2:0], corr[4*DIGITS-1]};
                    cnt     <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        bcd   <= shifted;
`ifdef FIB_BCD_BLANK_EN
                        blank <= blank_nxt;
`endif
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : fib_bcd_conv

// File: tb/tb_fib_bcd_conv.sv
// ---------------------------------------------------------------------------
// tb_fib_bcd_conv -- scoreboard bench for fib_bcd_conv. Each accepted start
// pushes the decimal expansion of the value (plus the blanking mask and the
// cycle on which done must appear) into a queue; a monitor pops an entry on
// every done strobe and compares.
// ---------------------------------------------------------------------------
module tb_fib_bcd_conv;
    import fib_pkg::*;

    localparam int IN_W   = FIB_W;
    localparam int DIGITS = FIB_DIGITS;

    logic                clk = 1'b0;
    logic                rst;
    logic                st;
    logic [IN_W-1:0]     bin;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;
`ifdef FIB_BCD_BLANK_EN
    logic [DIGITS-1:0]   blank;
`endif

    fib_bcd_conv #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .st    (st),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
`ifdef FIB_BCD_BLANK_EN
        ,
        .blank (blank)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int range_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4*DIGITS-1:0] bcd;
        logic [DIGITS-1:0]   blank;
        int                  due;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Decimal expansion by repeated division.
    function automatic logic [4*DIGITS-1:0] to_bcd(input longint unsigned v);
        logic [4*DIGITS-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Digit i and all above are zero exactly when v < 10^i.
    function automatic logic [DIGITS-1:0] blank_ref(input longint unsigned v);
        logic [DIGITS-1:0] m;
        longint unsigned   p;
        m = '0;
        p = 1;
        for (int i = 1; i < DIGITS; i++) begin
            p = p * 10;
            m[i] = (v < p);
        end
        return m;
    endfunction

    // Drive a start for one cycle; push an expectation if it must be accepted.
    task automatic issue(input logic [IN_W-1:0] value, input bit accepted);
        exp_t e;
        st  = 1'b1;
        bin = value;
        if (accepted) begin
            e.bcd   = to_bcd(longint'(value));
            e.blank = blank_ref(longint'(value));
            e.due   = cyc + 1 + IN_W;
            exp_q.push_back(e);
        end
        @(negedge clk);
        st  = 1'b0;
        bin = $urandom;
    endtask

    // Count cycles with busy high until it falls, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("idle_timeout", 64'(busy), 64'd0);
    endtask

    // Monitor: every done strobe consumes one expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done_queue_size", 64'(exp_q.size()), 64'd1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("bcd", 64'(bcd), 64'(e.bcd));
`ifdef FIB_BCD_BLANK_EN
                check("blank", 64'(blank), 64'(e.blank));
`endif
                check("done_latency_cycle", 64'(cyc), 64'(e.due));
                check("busy_during_done", 64'(busy), 64'd1);
            end
        end
    end

    // Every scratch digit must stay a legal BCD digit throughout SHIFT.
    always @(negedge clk) begin
        if (!rst && dut.state == SHIFT) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (dut.scratch[4*d +: 4] > 4'd9) range_bad++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [IN_W-1:0] fib [0:47];

        rst = 1'b1;
        st  = 1'b1;     // reset must win over a simultaneous start
        bin = 32'd12345;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_bcd", 64'(bcd), 64'd0);
`ifdef FIB_BCD_BLANK_EN
        check("reset_blank", 64'(blank), 64'(10'b1111111110));
`endif
        st  = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset_busy", 64'(busy), 64'd0);

        // Zero input.
        issue(32'd0, 1'b1);
        wait_idle(n);

        // F47: busy must span 33 cycles.
        issue(32'd2971215073, 1'b1);
        wait_idle(n);
        check("f47_busy_cycles", 64'(n), 64'd33);

        // Largest value.
        issue(32'hFFFF_FFFF, 1'b1);
        wait_idle(n);

        // Start and bin change during SHIFT are ignored; next idle start works.
        issue(32'd55, 1'b1);
        repeat (9) @(negedge clk);
        st  = 1'b1;
        bin = $urandom;
        @(negedge clk);
        st  = 1'b0;
        bin = $urandom;
        wait_idle(n);
        issue($urandom, 1'b1);
        wait_idle(n);

        // Reset in the middle of SHIFT aborts without a done pulse.
        issue($urandom, 1'b0);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_bcd", 64'(bcd), 64'd0);
        repeat (40) @(negedge clk);
        check("abort_still_idle", 64'(busy), 64'd0);
        issue(32'd144, 1'b1);
        wait_idle(n);

        // Back-to-back Fibonacci chain F0..F47.
        fib[0] = 32'd0;
        fib[1] = 32'd1;
        for (int k = 2; k < 48; k++) fib[k] = fib[k-1] + fib[k-2];
        for (int k = 0; k < 48; k++) begin
            issue(fib[k], 1'b1);
            wait_idle(n);
        end

        // Random values.
        for (int k = 0; k < 20; k++) begin
            issue($urandom, 1'b1);
            wait_idle(n);
        end

        repeat (5) @(negedge clk);
        check("pending_expectations", 64'(exp_q.size()), 64'd0);
        check("scratch_digit_range", 64'(range_bad), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fib_bcd_conv
